// File: rtl/pc_sequencer.sv
// pc_sequencer: PC select arbitration plus interrupt entry (drain, push return PC, vector, handler).
// Optional interrupt statistics counter enabled by defining PC_SEQ_INT_STATS_EN.
module pc_sequencer #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        intr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        call_d2e,
    input  logic        push_ack,
    input  logic        ret_done,
    output logic [1:0]  pc_src,
    output logic [1:0]  interrupt_signal,
    output logic [1:0]  first_time_call,
    output logic        flush,
    output logic        push_pc,
    output logic [15:0] push_data,
    output logic        in_handler,
    output logic        int_pending,
    output logic [15:0] int_count
);
    typedef enum logic [2:0] {RUN, DRAIN, PUSH_HI, PUSH_LO, VECTOR, HANDLER} state_t;
    state_t      state;
    logic [31:0] ret_addr;
    logic [2:0]  cnt;
    logic        intr_q, stall_q;
    logic        arb, call, br, st, acc;
    always_comb begin
        arb = state == RUN || state == HANDLER;
        call = arb && call_d2e;
        br = arb && !call_d2e && branch_taken;
        st = arb && !call_d2e && !branch_taken && stall && !stall_q;
        acc = state == RUN && !call_d2e && !branch_taken && !(stall && !stall_q) && int_pending;
    end
    // Outputs are forced low while reset is asserted so the push port drops immediately.
    always_comb begin
        first_time_call = (!reset && call) ? 2'b11 : 2'b00;
        pc_src = reset ? 2'b00 : br ? 2'b01 : st ? 2'b10 : 2'b00;
        flush = !reset && (br || acc || !arb);
        push_pc = !reset && (state == PUSH_HI || state == PUSH_LO);
        push_data = reset ? 16'h0000 : state == PUSH_HI ? ret_addr[31:16] :
                    state == PUSH_LO ? ret_addr[15:0] : 16'h0000;
        interrupt_signal = (!reset && state == VECTOR) ? 2'b11 : 2'b00;
        in_handler = !reset && state == HANDLER;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            ret_addr <= 32'h0;
            cnt <= 3'd0;
            intr_q <= 1'b0;
            stall_q <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            intr_q <= intr;
            stall_q <= stall;
            int_pending <= (int_pending && !acc) || (intr && !intr_q);
            case (state)
                RUN: if (acc) begin
                    ret_addr <= pc_in;
                    cnt <= 3'(DRAIN_CYCLES - 1);
                    state <= DRAIN;
                end
                DRAIN: if (cnt == 3'd0) state <= PUSH_HI; else cnt <= cnt - 3'd1;
                PUSH_HI: if (push_ack) state <= PUSH_LO;
                PUSH_LO: if (push_ack) state <= VECTOR;
                VECTOR: state <= HANDLER;
                HANDLER: if (ret_done) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
`ifdef PC_SEQ_INT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) int_count <= 16'h0000;
        else if (state == PUSH_LO && push_ack && int_count != 16'hFFFF) int_count <= int_count + 16'h0001;
    end
`else
    assign int_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, directed interrupt sequences and randomized run against a reference model.
module tb_pc_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        intr = 1'b0, stall = 1'b0, branch_taken = 1'b0, call_d2e = 1'b0, push_ack = 1'b0, ret_done = 1'b0;
    logic [1:0]  pc_src, interrupt_signal, first_time_call;
    logic        flush, push_pc, in_handler, int_pending;
    logic [15:0] push_data, int_count;
    int          errors = 0, checks = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .intr(intr), .stall(stall),
        .branch_taken(branch_taken), .call_d2e(call_d2e), .push_ack(push_ack), .ret_done(ret_done),
        .pc_src(pc_src), .interrupt_signal(interrupt_signal), .first_time_call(first_time_call),
        .flush(flush), .push_pc(push_pc), .push_data(push_data), .in_handler(in_handler),
        .int_pending(int_pending), .int_count(int_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic c, b, s, i, a, r, input logic [31:0] pc);
        @(negedge clk);
        call_d2e = c; branch_taken = b; stall = s; intr = i; push_ack = a; ret_done = r; pc_in = pc;
        #1;
    endtask

    function automatic logic [15:0] stat(input int n);
`ifdef PC_SEQ_INT_STATS_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    typedef struct {
        logic c, b, s;
        logic [1:0] ps, ftc;
        logic fl;
    } vec_t;
    vec_t tbl[10];

    logic [15:0] words[$];
    int          drain, cnt_m;
    bit          vec, hand, pend, iq, sq, act, acc;
    logic [1:0]  e_ps, e_ftc, e_isig;
    logic        e_fl, e_push;
    logic [15:0] e_data;
    logic [15:0] exp_w[2];

    initial begin
        tbl[0] = '{0, 0, 0, 2'b00, 2'b00, 0};
        tbl[1] = '{0, 0, 1, 2'b10, 2'b00, 0};
        tbl[2] = '{0, 0, 1, 2'b00, 2'b00, 0};
        tbl[3] = '{0, 0, 1, 2'b00, 2'b00, 0};
        tbl[4] = '{0, 0, 0, 2'b00, 2'b00, 0};
        tbl[5] = '{1, 1, 0, 2'b00, 2'b11, 0};
        tbl[6] = '{0, 1, 0, 2'b01, 2'b00, 1};
        tbl[7] = '{1, 0, 0, 2'b00, 2'b11, 0};
        tbl[8] = '{0, 0, 1, 2'b10, 2'b00, 0};
        tbl[9] = '{0, 1, 1, 2'b01, 2'b00, 1};
        repeat (2) @(negedge clk);
        #1;
        chk("reset_flush", flush, 0);
        chk("reset_push", push_pc, 0);
        chk("reset_count", int_count, 0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].c, tbl[i].b, tbl[i].s, 0, 0, 0, 32'h0);
            chk($sformatf("tbl%0d_pc_src", i), pc_src, tbl[i].ps);
            chk($sformatf("tbl%0d_ftc", i), first_time_call, tbl[i].ftc);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].fl);
        end
        // Basic interrupt entry at pc 0x40 with two-cycle delayed acks.
        cyc(0, 0, 0, 1, 0, 0, 32'h40);
        chk("t4_edge_flush", flush, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h40);
        chk("t4_accept_flush", flush, 1);
        chk("t4_accept_pend", int_pending, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 32'h40);
            chk("t4_drain_flush", flush, 1);
            chk("t4_drain_push", push_pc, 0);
        end
        exp_w[0] = 16'h0000; exp_w[1] = 16'h0040;
        for (int w = 0; w < 2; w++)
            for (int j = 0; j < 3; j++) begin
                cyc(0, 0, 0, 0, j == 2, 0, 32'h40);
                chk("t4_push_pc", push_pc, 1);
                chk("t4_push_data", push_data, exp_w[w]);
                chk("t4_push_flush", flush, 1);
            end
        cyc(0, 0, 0, 0, 0, 0, 32'h40);
        chk("t4_vector", interrupt_signal, 2'b11);
        chk("t4_vector_push", push_pc, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h40);
        chk("t4_handler", in_handler, 1);
        chk("t4_handler_isig", interrupt_signal, 0);
        chk("t4_handler_flush", flush, 0);
        chk("t4_count", int_count, stat(1));
        // Two edges inside the handler collapse into one pending interrupt.
        cyc(0, 0, 0, 1, 0, 0, 32'h50);
        cyc(0, 0, 0, 0, 0, 0, 32'h50);
        cyc(0, 0, 0, 1, 0, 0, 32'h50);
        cyc(0, 0, 0, 0, 0, 0, 32'h50);
        chk("t6_pending", int_pending, 1);
        chk("t6_no_accept", flush, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h50);
        chk("t6_retdone_handler", in_handler, 1);
        chk("t6_retdone_flush", flush, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h50);
        chk("t6_accept_flush", flush, 1);
        chk("t6_accept_run", in_handler, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h50);
        chk("t6_pending_cleared", int_pending, 0);
        for (int k = 0; k < 20 && interrupt_signal != 2'b11; k++) cyc(0, 0, 0, 0, 1, 0, 32'h50);
        chk("t6_vector_reached", interrupt_signal, 2'b11);
        chk("t6_count", int_count, stat(2));
        cyc(0, 0, 0, 0, 0, 1, 32'h50);
        chk("t6_second_handler", in_handler, 1);
        // Edge together with branch: branch wins, acceptance deferred, later pc pushed.
        cyc(0, 1, 0, 1, 0, 0, 32'h10);
        chk("t5_branch_pc_src", pc_src, 2'b01);
        chk("t5_branch_pend", int_pending, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'h100);
        chk("t5_defer_pc_src", pc_src, 2'b01);
        chk("t5_defer_pend", int_pending, 1);
        cyc(0, 0, 0, 0, 0, 0, 32'h12345678);
        chk("t5_accept_flush", flush, 1);
        chk("t5_accept_pc_src", pc_src, 2'b00);
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("t5_push_hi", push_data, 16'h1234);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("t5_push_lo", push_data, 16'h5678);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("t5_vector", interrupt_signal, 2'b11);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);
        // Asynchronous reset in the middle of the high-word push.
        cyc(0, 0, 0, 1, 0, 0, 32'hABCD0000);
        cyc(0, 0, 0, 0, 0, 0, 32'hABCD0000);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 32'hABCD0000);
        cyc(0, 0, 0, 0, 0, 0, 32'hABCD0000);
        chk("t1_in_push_hi", push_data, 16'hABCD);
        #1 reset = 1'b1;
        #1;
        chk("t1_async_push", push_pc, 0);
        chk("t1_async_data", push_data, 0);
        chk("t1_async_flush", flush, 0);
        chk("t1_async_count", int_count, 0);
        @(negedge clk); reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("t1_after_push", push_pc, 0);
        chk("t1_after_flush", flush, 0);
        chk("t1_after_handler", in_handler, 0);
        // Randomized run against the reference model.
        words = {}; drain = 0; cnt_m = 0; vec = 0; hand = 0; pend = 0; iq = 0; sq = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(9) == 0) intr = ~intr;
            call_d2e = $urandom_range(9) == 0;
            branch_taken = $urandom_range(6) == 0;
            stall = $urandom_range(4) == 0;
            push_ack = $urandom_range(1) == 0;
            ret_done = $urandom_range(9) == 0;
            pc_in = $urandom;
            #1;
            act = drain > 0 || words.size() > 0 || vec;
            e_ps = 0; e_ftc = 0; e_fl = 0; e_push = 0; e_data = 0; e_isig = 0; acc = 0;
            if (act) begin
                e_fl = 1;
                if (drain == 0 && words.size() > 0) begin e_push = 1; e_data = words[0]; end
                else if (drain == 0) e_isig = 2'b11;
            end else if (call_d2e) e_ftc = 2'b11;
            else if (branch_taken) begin e_ps = 2'b01; e_fl = 1; end
            else if (stall && !sq) e_ps = 2'b10;
            else if (pend && !hand) begin acc = 1; e_fl = 1; end
            chk("rnd_pc_src", pc_src, e_ps);
            chk("rnd_ftc", first_time_call, e_ftc);
            chk("rnd_flush", flush, e_fl);
            chk("rnd_push_pc", push_pc, e_push);
            chk("rnd_push_data", push_data, e_data);
            chk("rnd_isig", interrupt_signal, e_isig);
            chk("rnd_in_handler", in_handler, hand && !act);
            chk("rnd_pending", int_pending, pend);
            chk("rnd_count", int_count, stat(cnt_m));
            @(posedge clk);
            if (acc) begin drain = 3; words = '{pc_in[31:16], pc_in[15:0]}; vec = 1; end
            else if (drain > 0) drain--;
            else if (words.size() > 0) begin
                if (push_ack) begin
                    void'(words.pop_front());
                    if (words.size() == 0 && cnt_m < 65535) cnt_m++;
                end
            end else if (vec) begin vec = 0; hand = 1; end
            else if (hand && ret_done) hand = 0;
            pend = (pend && !acc) || (intr && !iq);
            iq = intr; sq = stall;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
